// File: rtl/des_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : des_ctrl_pkg
// Description : Shared opcodes, error codes and FSM encoding for the
//               UART-to-DES command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package des_ctrl_pkg;

    localparam logic [7:0] OP_KEY = 8'h4B;
    localparam logic [7:0] OP_ENC = 8'h45;
    localparam logic [7:0] OP_DEC = 8'h44;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_BADOP   = 3'd1;
    localparam logic [2:0] ERR_TIMEOUT = 3'd2;
    localparam logic [2:0] ERR_OVERRUN = 3'd3;
    localparam logic [2:0] ERR_NOKEY   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_KEY       = 3'd1,
        ST_BLOCK     = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/byte_shift64.sv
`default_nettype none
// ============================================================================
// Module      : byte_shift64
// Description : 8-byte left-shift assembler with byte count; o_next_word is
//               the word as it will look once i_din is shifted in.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_shift64 (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_shift_en,
    input  logic [7:0]  i_din,
    output logic [2:0]  o_count,
    output logic [63:0] o_next_word
);

    logic [63:0] r_shift;
    logic [2:0]  r_count;

    assign o_next_word = {r_shift[55:0], i_din};
    assign o_count     = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (i_shift_en) begin
            r_shift <= o_next_word;
            r_count <= r_count + 3'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_des_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_des_cmd_ctrl
// Description : Parses opcode + 8-byte payload frames from the UART and loads
//               the DES key or launches one DES operation via start/done.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_des_cmd_ctrl
    import des_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 200_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [63:0] des_key,
    output logic [63:0] des_block,
    output logic        des_decrypt,
    output logic        des_start,
    input  logic        des_done,
    output logic        key_loaded,
    output logic        busy,
    output logic        err_valid,
    output logic [2:0]  err_code
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state, w_state_nxt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_pend_dec;
    logic [63:0]      r_des_key, r_des_block;
    logic             r_des_decrypt, r_des_start, r_key_loaded;
    logic             r_err_valid;
    logic [2:0]       r_err_code;

    logic        w_frame_start, w_shift_en, w_tmo_inc;
    logic        w_pend_set, w_pend_val;
    logic        w_key_load, w_blk_load, w_start_nxt;
    logic        w_err_det;
    logic [2:0]  w_err_code;
    logic [2:0]  w_byte_cnt;
    logic [63:0] w_next_word;

    byte_shift64 u_shift (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_frame_start),
        .i_shift_en  (w_shift_en),
        .i_din       (rx_data),
        .o_count     (w_byte_cnt),
        .o_next_word (w_next_word)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        w_shift_en    = 1'b0;
        w_tmo_inc     = 1'b0;
        w_pend_set    = 1'b0;
        w_pend_val    = 1'b0;
        w_key_load    = 1'b0;
        w_blk_load    = 1'b0;
        w_start_nxt   = 1'b0;
        w_err_det     = 1'b0;
        w_err_code    = ERR_NONE;
        case (r_state)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == OP_KEY) begin
                        w_state_nxt   = ST_KEY;
                        w_frame_start = 1'b1;
                    end else if (rx_data == OP_ENC || rx_data == OP_DEC) begin
                        w_state_nxt   = ST_BLOCK;
                        w_frame_start = 1'b1;
                        w_pend_set    = 1'b1;
                        w_pend_val    = (rx_data == OP_DEC);
                    end else begin
                        w_err_det  = 1'b1;
                        w_err_code = ERR_BADOP;
                    end
                end
            end
            ST_KEY, ST_BLOCK: begin
                if (rx_valid) begin
                    w_shift_en = 1'b1;
                    if (w_byte_cnt == 3'd7) begin
                        if (r_state == ST_KEY) begin
                            w_key_load  = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_blk_load  = 1'b1;
                            w_state_nxt = ST_ISSUE;
                        end
                    end
                end else if (r_tmo_cnt == C_TMO_LAST) begin
                    w_err_det   = 1'b1;
                    w_err_code  = ERR_TIMEOUT;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end
            ST_ISSUE: begin
                // A missing key is the terminal outcome, so it wins over an overrun byte
                if (!r_key_loaded) begin
                    w_err_det   = 1'b1;
                    w_err_code  = ERR_NOKEY;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_start_nxt = 1'b1;
                    w_state_nxt = ST_WAIT_DONE;
                    if (rx_valid) begin
                        w_err_det  = 1'b1;
                        w_err_code = ERR_OVERRUN;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (rx_valid) begin
                    w_err_det  = 1'b1;
                    w_err_code = ERR_OVERRUN;
                end
                if (des_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_tmo_cnt     <= '0;
            r_pend_dec    <= 1'b0;
            r_des_key     <= '0;
            r_des_block   <= '0;
            r_des_decrypt <= 1'b0;
            r_des_start   <= 1'b0;
            r_key_loaded  <= 1'b0;
            r_err_valid   <= 1'b0;
            r_err_code    <= ERR_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_des_start <= w_start_nxt;
            r_err_valid <= w_err_det;
            if (w_frame_start || w_shift_en) begin
                r_tmo_cnt <= '0;
            end else if (w_tmo_inc) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_pend_set) begin
                r_pend_dec <= w_pend_val;
            end
            if (w_key_load) begin
                r_des_key    <= w_next_word;
                r_key_loaded <= 1'b1;
            end
            if (w_blk_load) begin
                r_des_block   <= w_next_word;
                r_des_decrypt <= r_pend_dec;
            end
            if (w_err_det) begin
                r_err_code <= w_err_code;
            end
        end
    end

    assign des_key     = r_des_key;
    assign des_block   = r_des_block;
    assign des_decrypt = r_des_decrypt;
    assign des_start   = r_des_start;
    assign key_loaded  = r_key_loaded;
    assign busy        = (r_state != ST_IDLE);
    assign err_valid   = r_err_valid;
    assign err_code    = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_uart_des_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_des_cmd_ctrl
// Description : Directed self-checking bench for uart_des_cmd_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_des_cmd_ctrl;

    localparam int TMO = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        des_done = 1'b0;
    logic [63:0] des_key, des_block;
    logic        des_decrypt, des_start, key_loaded, busy, err_valid;
    logic [2:0]  err_code;

    int total = 0;
    int fails = 0;
    int err_pulses = 0;
    int start_pulses = 0;
    int e0, s0;

    uart_des_cmd_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .des_key     (des_key),
        .des_block   (des_block),
        .des_decrypt (des_decrypt),
        .des_start   (des_start),
        .des_done    (des_done),
        .key_loaded  (key_loaded),
        .busy        (busy),
        .err_valid   (err_valid),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_valid) err_pulses++;
        if (des_start) start_pulses++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [63:0] payload);
        send_byte(op);
        for (int i = 0; i < 8; i++) send_byte(payload[63-8*i -: 8]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_key"},    des_key, 64'h0);
        check({tag, "_block"},  des_block, 64'h0);
        check({tag, "_flags"},  {des_decrypt, des_start, key_loaded, busy, err_valid}, 64'h0);
        check({tag, "_code"},   err_code, 64'h0);
    endtask

    initial begin
        // Reset state
        tick(2);
        check_all_zero("reset");
        reset = 1'b0;
        tick(1);

        // 1: key load
        e0 = err_pulses; s0 = start_pulses;
        send_frame(8'h4B, 64'h0123456789ABCDEF);
        check("key_value", des_key, 64'h0123456789ABCDEF);
        check("key_loaded", key_loaded, 1);
        check("key_busy", busy, 0);
        tick(2);
        check("key_no_err", err_pulses - e0, 0);
        check("key_no_start", start_pulses - s0, 0);

        // 2: encrypt with start/done handshake
        e0 = err_pulses; s0 = start_pulses;
        send_frame(8'h45, 64'h0001020304050607);
        check("enc_block", des_block, 64'h0001020304050607);
        check("enc_decrypt", des_decrypt, 0);
        check("enc_busy_issue", busy, 1);
        check("enc_start_early", des_start, 0);
        tick(1);
        check("enc_start_pulse", des_start, 1);
        tick(1);
        check("enc_start_single", des_start, 0);
        tick(13);
        check("enc_busy_wait", busy, 1);
        check("enc_block_stable", des_block, 64'h0001020304050607);
        des_done = 1'b1;
        tick(1);
        des_done = 1'b0;
        check("enc_busy_done", busy, 0);
        check("enc_start_count", start_pulses - s0, 1);
        check("enc_no_err", err_pulses - e0, 0);

        // 3: decrypt without key, then bad opcode
        reset = 1'b1;
        #2;
        check("rst3_keyloaded", key_loaded, 0);
        tick(1);
        reset = 1'b0;
        s0 = start_pulses;
        send_frame(8'h44, 64'h1111111111111111);
        check("nokey_issue_busy", busy, 1);
        tick(1);
        check("nokey_err_valid", err_valid, 1);
        check("nokey_err_code", err_code, 4);
        check("nokey_idle", busy, 0);
        tick(1);
        check("nokey_err_pulse_end", err_valid, 0);
        check("nokey_no_start", start_pulses - s0, 0);
        send_byte(8'h5A);
        check("badop_err_valid", err_valid, 1);
        check("badop_err_code", err_code, 1);
        check("badop_idle", busy, 0);

        // 4: timeout on a partial key frame
        send_frame(8'h4B, 64'h1122334455667788);
        check("tmo_prekey", des_key, 64'h1122334455667788);
        send_byte(8'h4B);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        tick(TMO - 1);
        check("tmo_not_yet", err_valid, 0);
        check("tmo_busy_before", busy, 1);
        tick(1);
        check("tmo_err_valid", err_valid, 1);
        check("tmo_err_code", err_code, 2);
        check("tmo_idle", busy, 0);
        check("tmo_key_kept", des_key, 64'h1122334455667788);
        send_frame(8'h4B, 64'h0123456789ABCDEF);
        check("tmo_reload_key", des_key, 64'h0123456789ABCDEF);
        check("tmo_reload_idle", busy, 0);

        // 5: overrun during WAIT_DONE, including alongside des_done
        send_frame(8'h45, 64'hF0F1F2F3F4F5F6F7);
        tick(1);
        check("ovr_started", des_start, 1);
        e0 = err_pulses;
        send_byte(8'h45);
        check("ovr_err_valid", err_valid, 1);
        check("ovr_err_code", err_code, 3);
        check("ovr_still_busy", busy, 1);
        check("ovr_block_kept", des_block, 64'hF0F1F2F3F4F5F6F7);
        tick(1);
        rx_data  = 8'h45;
        rx_valid = 1'b1;
        des_done = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        des_done = 1'b0;
        check("ovr_done_idle", busy, 0);
        check("ovr_done_err", err_valid, 1);
        check("ovr_err_count", err_pulses - e0, 1);
        tick(1);
        check("ovr_err_total", err_pulses - e0, 2);
        s0 = start_pulses;
        send_frame(8'h44, 64'h0F1E2D3C4B5A6978);
        check("dec_block", des_block, 64'h0F1E2D3C4B5A6978);
        check("dec_decrypt", des_decrypt, 1);
        tick(1);
        check("dec_start", des_start, 1);
        tick(3);
        des_done = 1'b1;
        tick(1);
        des_done = 1'b0;
        check("dec_idle", busy, 0);
        check("dec_start_count", start_pulses - s0, 1);

        // 6: asynchronous reset mid-payload and during WAIT_DONE
        send_byte(8'h45);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        check("rstblk_busy", busy, 1);
        reset = 1'b1;
        #2;
        check_all_zero("rst_midblock");
        tick(1);
        reset = 1'b0;
        send_frame(8'h4B, 64'hA5A5A5A5A5A5A5A5);
        send_frame(8'h45, 64'h0102030405060708);
        tick(1);
        check("rstwd_start", des_start, 1);
        check("rstwd_busy", busy, 1);
        reset = 1'b1;
        #2;
        check_all_zero("rst_waitdone");
        tick(1);
        reset = 1'b0;
        tick(2);
        check("post_rst_idle", busy, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
`default_nettype wire
